// File: rtl/dmem_bus_bridge.sv
// dmem_bus_bridge
//   Bridges a single-cycle core's data-memory port onto a variable-latency
//   valid/ready memory bus. An aligned load or store becomes a registered bus
//   request followed, for loads, by a response phase. The core is held with
//   `stall` until the access completes. A misaligned access never reaches the
//   bus and raises misalign_err. A load whose response never arrives raises
//   timeout_err after TIMEOUT cycles of waiting.
//
// Ports
//   clk, rst_n          clock; synchronous reset, active HIGH despite the name
//   mem_read/mem_write  core load/store request, held by the core while stalled
//   addr, write_data    core byte address and store data
//   read_data           load data, valid in the DONE cycle
//   stall               core hold (combinational)
//   bus_req_valid/ready request handshake; bus_we/bus_addr/bus_wdata payload
//   bus_rsp_valid/rdata read response
//   misalign_err        one-cycle pulse after a misaligned access
//   timeout_err         one-cycle pulse when a read response times out
module dmem_bus_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              stall,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_rsp_valid,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              misalign_err,
    output logic              timeout_err
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DONE
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             access;
    logic             aligned;
    logic             expired;

    assign access  = mem_read | mem_write;
    assign aligned = (addr[1:0] == 2'b00);
    assign cnt_inc = cnt + CNT_W'(1);
    // Last permitted wait cycle: this RESP cycle without a response is the TIMEOUT-th.
    assign expired = (cnt_inc == CNT_W'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst_n) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                if (access && aligned) begin
                    state_nxt = REQ;
                    stall     = 1'b1;
                end
            end
            REQ: begin
                stall = 1'b1;
                if (bus_req_ready) state_nxt = bus_we ? DONE : RESP;
            end
            RESP: begin
                stall = 1'b1;
                if (bus_rsp_valid || expired) state_nxt = DONE;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // The core must be free to run while the bridge is being reset.
        if (rst_n) stall = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            bus_req_valid <= 1'b0;
            bus_we        <= 1'b0;
            bus_addr      <= '0;
            bus_wdata     <= '0;
            read_data     <= '0;
            misalign_err  <= 1'b0;
            timeout_err   <= 1'b0;
            cnt           <= '0;
        end else begin
            misalign_err <= 1'b0;
            timeout_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (access) begin
                        if (aligned) begin
                            // Load+store together resolves to a store.
                            bus_addr      <= addr;
                            bus_wdata     <= write_data;
                            bus_we        <= mem_write;
                            bus_req_valid <= 1'b1;
                        end else begin
                            misalign_err <= 1'b1;
                            read_data    <= '0;
                        end
                    end
                end
                REQ: begin
                    if (bus_req_ready) begin
                        bus_req_valid <= 1'b0;
                        cnt           <= '0;
                    end
                end
                RESP: begin
                    if (bus_rsp_valid) begin
                        read_data <= bus_rdata;
                    end else begin
                        cnt <= cnt_inc;
                        if (expired) begin
                            read_data   <= '0;
                            timeout_err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
